// File: rtl/fifo_word_packer.sv
// Drains WIDTH-bit entries from a synchronous FIFO and packs LANES of them into one
// wide word on a valid/ready port; flush emits a partial word with a lane-keep mask.
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_dout,
    output logic                   fifo_rd_en,
    input  logic                   flush,
    output logic [WIDTH*LANES-1:0] word_data,
    output logic [LANES-1:0]       word_keep,
    output logic                   word_valid,
    input  logic                   word_ready
);
    localparam int CW = $clog2(LANES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_run;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH*LANES-1:0] r_data;
    logic [LANES-1:0]       r_keep;
    logic                   r_valid;

    logic w_cap;
    logic w_full;
    logic w_emit;

    // Read enable depends only on registered state, so the FIFO sees no comb path from its own flags.
    assign fifo_rd_en = r_run & (r_state == FILL);
    assign w_cap      = fifo_rd_en & ~fifo_empty;
    assign w_full     = w_cap & (r_cnt == CW'(LANES - 1));
    assign w_emit     = w_full | (flush & ((r_cnt != '0) | w_cap));

    assign word_data  = r_data;
    assign word_keep  = r_keep;
    assign word_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                FILL: begin
                    if (w_cap) begin
                        r_data[int'(r_cnt)*WIDTH +: WIDTH] <= fifo_dout;
                        r_keep[r_cnt]                      <= 1'b1;
                        r_cnt                              <= r_cnt + CW'(1);
                    end
                    if (w_emit) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // A partial word leaves cnt nonzero, so it is cleared here along with the lanes.
                    if (r_valid && word_ready) begin
                        r_state <= FILL;
                        r_valid <= 1'b0;
                        r_keep  <= '0;
                        r_data  <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural FIFO + packing model feeding a scoreboard,
// with a negedge monitor comparing every offered word against the queue head.
module tb_fifo_word_packer;
    localparam int W = 8;
    localparam int L = 4;

    typedef struct packed {
        logic [W*L-1:0] d;
        logic [L-1:0]   k;
    } word_t;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           flush      = 1'b0;
    logic           word_ready = 1'b1;
    logic           gap        = 1'b0;
    logic [W-1:0]   head       = '0;
    logic [W-1:0]   fifo_dout;
    logic           fifo_rd_en;
    logic [W*L-1:0] word_data;
    logic [L-1:0]   word_keep;
    logic           word_valid;

    logic [W-1:0] src_q[$];
    logic [W-1:0] cur[$];
    word_t        exp_q[$];

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int words  = 0;
    logic [W*L-1:0] last_d = '0;
    logic [L-1:0]   last_k = '0;

    fifo_word_packer #(.WIDTH(W), .LANES(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    assign fifo_dout = (fifo_rd_en && !fifo_empty) ? head : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // FIFO source and packing reference model: pops at the edge, groups entries into words.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty && src_q.size() > 0) begin
            cur.push_back(src_q.pop_front());
            pops++;
        end
        if (cur.size() == L || (flush && cur.size() > 0)) begin
            word_t w;
            w = '0;
            for (int i = 0; i < cur.size(); i++) begin
                w.d[i*W +: W] = cur[i];
                w.k[i]        = 1'b1;
            end
            exp_q.push_back(w);
            cur.delete();
        end
    end

    always @(negedge clk) begin
        fifo_empty = (src_q.size() == 0) || gap;
        head       = (src_q.size() > 0) ? src_q[0] : '0;
    end

    always @(negedge rst_n) begin
        cur.delete();
        exp_q.delete();
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_vs_model", {63'd0, word_valid}, {63'd0, exp_q.size() != 0});
            if (word_valid) begin
                chk("rd_en_in_hold", {63'd0, fifo_rd_en}, 64'd0);
                if (exp_q.size() > 0) begin
                    chk("word_data", {32'd0, word_data}, {32'd0, exp_q[0].d});
                    chk("word_keep", {60'd0, word_keep}, {60'd0, exp_q[0].k});
                    if (word_ready) begin
                        last_d = word_data;
                        last_k = word_keep;
                        void'(exp_q.pop_front());
                        words++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            tick();
            n++;
        end
        if (pops < target) chk("pop_timeout", 64'(pops), 64'(target));
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words < target && n < budget) begin
            tick();
            n++;
        end
        if (words < target) chk("word_timeout", 64'(words), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p;
        int w;
        int n;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {63'd0, word_valid}, 64'd0);
        chk("rst_keep", {60'd0, word_keep}, 64'd0);
        chk("rst_data", {32'd0, word_data}, 64'd0);
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        rst_n = 1'b1;
        chk("rd_en_first_cycle", {63'd0, fifo_rd_en}, 64'd0);
        tick();
        chk("rd_en_after_run", {63'd0, fifo_rd_en}, 64'd1);

        // Full word
        w = words;
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        wait_words(w + 1, 50);
        chk("full_data", {32'd0, last_d}, 64'h44332211);
        chk("full_keep", {60'd0, last_k}, 64'hF);

        // Backpressure
        w = words;
        p = pops;
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
        repeat (10) tick();
        chk("bp_valid", {63'd0, word_valid}, 64'd1);
        chk("bp_data", {32'd0, word_data}, 64'h04030201);
        chk("bp_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("bp_pops", 64'(pops), 64'(p + 4));
        word_ready = 1'b1;
        wait_words(w + 2, 50);
        chk("bp_second", {32'd0, last_d}, 64'h08070605);

        // Partial flush
        w = words;
        p = pops;
        src_q.push_back(8'hAA); src_q.push_back(8'hBB);
        wait_pops(p + 2, 20);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_words(w + 1, 20);
        chk("partial_data", {32'd0, last_d}, 64'h0000BBAA);
        chk("partial_keep", {60'd0, last_k}, 64'h3);

        // Flush with nothing buffered
        w = words;
        repeat (2) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        chk("empty_flush_valid", {63'd0, word_valid}, 64'd0);
        chk("empty_flush_words", 64'(words), 64'(w));

        // Flush coincident with capture
        w = words;
        p = pops;
        src_q.push_back(8'hC1); src_q.push_back(8'hC2);
        wait_pops(p + 1, 20);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_words(w + 1, 20);
        chk("coinc_data", {32'd0, last_d}, 64'h0000C2C1);
        chk("coinc_keep", {60'd0, last_k}, 64'h3);

        // Flush on the LANES-th capture
        w = words;
        p = pops;
        src_q.push_back(8'hD1); src_q.push_back(8'hD2);
        src_q.push_back(8'hD3); src_q.push_back(8'hD4);
        wait_pops(p + 3, 20);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_words(w + 1, 20);
        chk("flush4_data", {32'd0, last_d}, 64'hD4D3D2D1);
        chk("flush4_keep", {60'd0, last_k}, 64'hF);
        repeat (3) tick();
        chk("flush4_single", 64'(words), 64'(w + 1));

        // Random traffic with empty gaps, backpressure and flushes
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) src_q.push_back(8'($urandom_range(1, 255)));
            gap        = ($urandom_range(0, 3) == 0);
            word_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        gap = 1'b0; word_ready = 1'b1; flush = 1'b0;
        n = 0;
        while (src_q.size() > 0 && n < 500) begin tick(); n++; end
        chk("drain_src", 64'(src_q.size()), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || word_valid) && n < 50) begin tick(); n++; end
        chk("drain_exp", 64'(exp_q.size()), 64'd0);
        chk("drain_cur", 64'(cur.size()), 64'd0);

        // Asynchronous reset mid-word
        p = pops;
        src_q.push_back(8'hE1); src_q.push_back(8'hE2); src_q.push_back(8'hE3);
        wait_pops(p + 3, 20);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, word_valid}, 64'd0);
        chk("arst_keep", {60'd0, word_keep}, 64'd0);
        chk("arst_data", {32'd0, word_data}, 64'd0);
        chk("arst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        src_q.push_back(8'hF1); src_q.push_back(8'hF2);
        src_q.push_back(8'hF3); src_q.push_back(8'hF4);
        repeat (2) tick();
        rst_n = 1'b1;
        p = pops;
        w = words;
        chk("rel_rd_en0", {63'd0, fifo_rd_en}, 64'd0);
        tick();
        chk("rel_no_pop", 64'(pops), 64'(p));
        chk("rel_rd_en1", {63'd0, fifo_rd_en}, 64'd1);
        wait_words(w + 1, 30);
        chk("rel_data", {32'd0, last_d}, 64'hF4F3F2F1);
        chk("rel_keep", {60'd0, last_k}, 64'hF);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
